// File: rtl/alarm_disp_pkg.sv
// ---------------------------------------------------------------------------
// alarm_disp_pkg
// Shared constants and types for the alarm-clock display scan path.
//   NUM_DIGITS      : number of multiplexed digit positions
//   digit_t         : digit index type (DIG_MINS0 .. DIG_DAYS)
//   seg_t           : one 7-segment code, bit SEG_A .. bit SEG_G, active-high
//   SEG_BLANK       : all segments off
//   is_time_digit() : true for the four time digits (the ones that blink)
// ---------------------------------------------------------------------------
package alarm_disp_pkg;

   localparam int unsigned NUM_DIGITS = 5;

   // Segment bit positions inside a 7-segment code.
   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   typedef logic [SEG_G:SEG_A] seg_t;
   typedef logic [2:0]         digit_t;

   localparam seg_t SEG_BLANK = 7'b0;

   // Digit positions; the value is also the bit position in the anode bus.
   localparam digit_t DIG_MINS0  = 3'd0;
   localparam digit_t DIG_MINS1  = 3'd1;
   localparam digit_t DIG_HOURS0 = 3'd2;
   localparam digit_t DIG_HOURS1 = 3'd3;
   localparam digit_t DIG_DAYS   = 3'd4;

   function automatic logic is_time_digit(input digit_t d);
      return (d <= DIG_HOURS1);
   endfunction

endpackage

// File: rtl/scan_timer.sv
// ---------------------------------------------------------------------------
// scan_timer
// Scan timebase for the display driver: digit-slot prescaler, digit index
// and the frame-based blink phase.
//   Clk, Clr        : clock, synchronous active-high reset
//   i_dblink_new    : dblink as it is being captured this cycle
//   i_dblink_snap   : dblink held in the snapshot for the current frame
//   o_slot_active   : current slot is past its anti-ghosting blank time
//   o_digit         : current digit index
//   o_frame_end     : last cycle of a frame (capture cycle), combinational
//   o_bph           : blink phase, 1 = time digits lit
// ---------------------------------------------------------------------------
module scan_timer
   import alarm_disp_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 2,
   parameter int BLINK_FRAMES = 50
) (
   input  logic   Clk,
   input  logic   Clr,
   input  logic   i_dblink_new,
   input  logic   i_dblink_snap,
   output logic   o_slot_active,
   output digit_t o_digit,
   output logic   o_frame_end,
   output logic   o_bph
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
   localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0] r_p;
   digit_t        r_d;
   logic [FW-1:0] r_f;
   logic          r_bph;

   logic w_p_wrap;
   logic w_frame_end;

   assign w_p_wrap    = (r_p == P_LAST);
   assign w_frame_end = w_p_wrap && (r_d == DIG_DAYS);

   always_ff @(posedge Clk) begin
      if (Clr) begin
         r_p   <= '0;
         r_d   <= DIG_MINS0;
         r_f   <= '0;
         r_bph <= 1'b1;
      end else begin
         r_p <= w_p_wrap ? '0 : r_p + 1'b1;
         if (w_p_wrap) begin
            r_d <= (r_d == DIG_DAYS) ? DIG_MINS0 : r_d + 1'b1;
         end
         if (w_frame_end) begin
            // Dropping dblink parks the phase in "on" so the next blink
            // sequence always starts lit. Counting only runs for frames that
            // were already blinking, which gives a full lit half-period first.
            if (!i_dblink_new) begin
               r_f   <= '0;
               r_bph <= 1'b1;
            end else if (i_dblink_snap) begin
               if (r_f == F_LAST) begin
                  r_f   <= '0;
                  r_bph <= ~r_bph;
               end else begin
                  r_f <= r_f + 1'b1;
               end
            end
         end
      end
   end

   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign o_slot_active = 1'b1;
      end else begin : g_blank
         assign o_slot_active = (r_p >= P_BLANK);
      end
   endgenerate

   assign o_digit     = r_d;
   assign o_frame_end = w_frame_end;
   assign o_bph       = r_bph;

endmodule

// File: rtl/display_scan_driver.sv
// ---------------------------------------------------------------------------
// display_scan_driver
// Time-multiplexes the alarm-clock display codes onto one shared segment bus
// and a 5-line digit-enable bus. Inputs are snapshotted once per frame (no
// tearing), each digit slot starts with blank time (anti-ghosting), and the
// time digits blink while the captured dblink is high.
//   Clk, Clr                  : clock, synchronous active-high reset
//   hours1..mins0, days       : 7-segment codes, active-high, bit0 = a
//   am, pm                    : DP indicators (hours1 DP, mins0 DP)
//   dblink                    : blink request for the four time digits
//   seg_out, dp_out           : shared segment / DP lines (SEG_ACTIVE_LOW)
//   an_out                    : digit enables, bit = digit index (AN_ACTIVE_LOW)
//   frame_tick                : one-cycle pulse after each completed frame
// All pins are registered: the pattern lags the scan counters by one clock.
// ---------------------------------------------------------------------------
module display_scan_driver
   import alarm_disp_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int BLANK_CYCLES   = 2,
   parameter int BLINK_FRAMES   = 50,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic       Clk,
   input  logic       Clr,
   input  logic [6:0] hours1,
   input  logic [6:0] hours0,
   input  logic [6:0] mins1,
   input  logic [6:0] mins0,
   input  logic [6:0] days,
   input  logic       am,
   input  logic       pm,
   input  logic       dblink,
   output logic [6:0] seg_out,
   output logic       dp_out,
   output logic [4:0] an_out,
   output logic       frame_tick
);

   // Frame snapshot
   seg_t [NUM_DIGITS-1:0] r_code;
   logic                  r_am;
   logic                  r_pm;
   logic                  r_dblink;

   // Registered pin values (logical polarity: 1 = lit / enabled)
   logic [NUM_DIGITS-1:0] r_an;
   seg_t                  r_seg;
   logic                  r_dp;
   logic                  r_frame_tick;

   logic                  w_slot_active;
   digit_t                w_digit;
   logic                  w_frame_end;
   logic                  w_bph;
   logic [NUM_DIGITS-1:0] w_an;
   seg_t                  w_seg;
   logic                  w_dp;

   scan_timer #(
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK_CYCLES),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_scan_timer (
      .Clk           (Clk),
      .Clr           (Clr),
      .i_dblink_new  (dblink),
      .i_dblink_snap (r_dblink),
      .o_slot_active (w_slot_active),
      .o_digit       (w_digit),
      .o_frame_end   (w_frame_end),
      .o_bph         (w_bph)
   );

   // Capture on the last cycle of the days slot; the whole next frame then
   // shows one consistent set of values.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         r_code   <= '0;
         r_am     <= 1'b0;
         r_pm     <= 1'b0;
         r_dblink <= 1'b0;
      end else if (w_frame_end) begin
         r_code[DIG_MINS0]  <= mins0;
         r_code[DIG_MINS1]  <= mins1;
         r_code[DIG_HOURS0] <= hours0;
         r_code[DIG_HOURS1] <= hours1;
         r_code[DIG_DAYS]   <= days;
         r_am               <= am;
         r_pm               <= pm;
         r_dblink           <= dblink;
      end
   end

   always_comb begin
      w_an  = '0;
      w_seg = SEG_BLANK;
      w_dp  = 1'b0;
      if (w_slot_active) begin
         w_an = NUM_DIGITS'(1) << w_digit;
         case (w_digit)
            DIG_MINS0:  w_seg = r_code[DIG_MINS0];
            DIG_MINS1:  w_seg = r_code[DIG_MINS1];
            DIG_HOURS0: w_seg = r_code[DIG_HOURS0];
            DIG_HOURS1: w_seg = r_code[DIG_HOURS1];
            DIG_DAYS:   w_seg = r_code[DIG_DAYS];
            default:    w_seg = SEG_BLANK;
         endcase
         w_dp = ((w_digit == DIG_HOURS1) && r_am) || ((w_digit == DIG_MINS0) && r_pm);
         // Off-phase blanks the time digits but keeps the anode on so the
         // slot timing (and perceived brightness of days) is unchanged.
         if (!w_bph && is_time_digit(w_digit)) begin
            w_seg = SEG_BLANK;
            w_dp  = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         r_an         <= '0;
         r_seg        <= SEG_BLANK;
         r_dp         <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_an         <= w_an;
         r_seg        <= w_seg;
         r_dp         <= w_dp;
         r_frame_tick <= w_frame_end;
      end
   end

   // Pin polarity is a static function of the parameters.
   assign seg_out    = (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;
   assign dp_out     = (SEG_ACTIVE_LOW != 0) ? ~r_dp  : r_dp;
   assign an_out     = (AN_ACTIVE_LOW  != 0) ? ~r_an  : r_an;
   assign frame_tick = r_frame_tick;

endmodule
